ahb_apb_arbiter: RTL and testbench

Two-master AHB arbiter placed in front of the AHB-to-APB bridge (`AHB_APB_SM`) so that two AHB masters share its single slave port. It grants ownership round-robin and hands over only at transfer boundaries, when the owner drives IDLE. It multiplexes the address phase and the data phase independently, and decodes `Hsel_APB` from an address window. Read data, `Hready_out` and `Hresp` from the bridge are broadcast back to both masters.

---
 rtl/ahb_apb_arbiter.sv | 129 ++++++++++++
 tb/tb_ahb_apb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_arbiter.sv
// Two-master round-robin AHB arbiter in front of the AHB-to-APB bridge, with APB window decode.
// Latency: grant/owner registered (1 cycle handover); address, write-data and response paths are combinational.
// Backpressure: every register holds while Hready_out is low; ownership moves only when the owner drives IDLE.
//
// Ports:
//   Hclk, Hrst                    clock, synchronous active-high reset
//   Hbusreq[1:0]                  per-master bus request
//   Haddr/Htrans/Hwrite/Hwdata_mK master K address phase and write data
//   Hready_out, Hresp, Hrdata     bridge response, broadcast as Hready_m/Hresp_m/Hrdata_m
//   Hgrant, Hmaster, Hmaster_d    one-hot grant, address-phase owner, data-phase owner
//   Haddr/Htrans/Hwrite/Hwdata    muxed bus to the bridge; Hsel_APB selects the bridge
module ahb_apb_arbiter #(
  parameter logic [31:0] APB_BASE = 32'h0000_0000,
  parameter logic [31:0] APB_SIZE = 32'h0001_0000
) (
  input  logic        Hclk,
  input  logic        Hrst,
  input  logic [1:0]  Hbusreq,
  input  logic [31:0] Haddr_m0,
  input  logic [31:0] Haddr_m1,
  input  logic [1:0]  Htrans_m0,
  input  logic [1:0]  Htrans_m1,
  input  logic        Hwrite_m0,
  input  logic        Hwrite_m1,
  input  logic [31:0] Hwdata_m0,
  input  logic [31:0] Hwdata_m1,
  input  logic        Hready_out,
  input  logic [1:0]  Hresp,
  input  logic [31:0] Hrdata,
  output logic [1:0]  Hgrant,
  output logic        Hmaster,
  output logic        Hmaster_d,
  output logic [31:0] Haddr,
  output logic [1:0]  Htrans,
  output logic        Hwrite,
  output logic [31:0] Hwdata,
  output logic        Hsel_APB,
  output logic        Hready_m,
  output logic [1:0]  Hresp_m,
  output logic [31:0] Hrdata_m
);

  localparam logic [1:0]  HTRANS_IDLE = 2'b00;
  localparam logic [31:0] WIN_MASK    = ~(APB_SIZE - 32'd1);

  typedef enum logic [1:0] {
    PARK = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] grant_d;

  // Next-state: PARK arbitrates immediately; an owner is only released
  // when it drives IDLE, so bursts (including BUSY) are never split.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      PARK: begin
        case (Hbusreq)
          2'b01:   state_d = OWN0;
          2'b10:   state_d = OWN1;
          2'b11:   state_d = last_q ? OWN0 : OWN1;
          default: state_d = PARK;
        endcase
      end
      OWN0: begin
        if (Htrans_m0 == HTRANS_IDLE) begin
          if (Hbusreq[1]) begin
            state_d = OWN1;
            last_d  = 1'b0;
          end else if (!Hbusreq[0]) begin
            state_d = PARK;
            last_d  = 1'b0;
          end
        end
      end
      OWN1: begin
        if (Htrans_m1 == HTRANS_IDLE) begin
          if (Hbusreq[0]) begin
            state_d = OWN0;
            last_d  = 1'b1;
          end else if (!Hbusreq[1]) begin
            state_d = PARK;
            last_d  = 1'b1;
          end
        end
      end
      default: state_d = PARK;
    endcase
  end

  // PARK keeps master 0 granted so its first request costs no cycle.
  assign grant_d = (state_d == OWN1) ? 2'b10 : 2'b01;

  always_ff @(posedge Hclk) begin
    if (Hrst) begin
      state_q   <= PARK;
      last_q    <= 1'b1;
      Hgrant    <= 2'b01;
      Hmaster   <= 1'b0;
      Hmaster_d <= 1'b0;
    end else if (Hready_out) begin
      state_q   <= state_d;
      last_q    <= last_d;
      Hgrant    <= grant_d;
      Hmaster   <= grant_d[1];
      // Data phase belongs to whoever owned the address phase just accepted.
      Hmaster_d <= Hmaster;
    end
  end

  // Address and data phases are muxed by separate owners.
  assign Haddr  = Hmaster   ? Haddr_m1  : Haddr_m0;
  assign Htrans = Hmaster   ? Htrans_m1 : Htrans_m0;
  assign Hwrite = Hmaster   ? Hwrite_m1 : Hwrite_m0;
  assign Hwdata = Hmaster_d ? Hwdata_m1 : Hwdata_m0;

  // Only NONSEQ/SEQ inside the window select the bridge.
  assign Hsel_APB = Htrans[1] && ((Haddr & WIN_MASK) == APB_BASE);

  assign Hready_m = Hready_out;
  assign Hresp_m  = Hresp;
  assign Hrdata_m = Hrdata;

endmodule

// File: tb/tb_ahb_apb_arbiter.sv
module tb_ahb_apb_arbiter;

  logic        Hclk = 1'b0;
  logic        Hrst;
  logic [1:0]  Hbusreq;
  logic [31:0] Haddr_m0, Haddr_m1;
  logic [1:0]  Htrans_m0, Htrans_m1;
  logic        Hwrite_m0, Hwrite_m1;
  logic [31:0] Hwdata_m0, Hwdata_m1;
  logic        Hready_out;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [1:0]  Hgrant;
  logic        Hmaster, Hmaster_d;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic        Hsel_APB;
  logic        Hready_m;
  logic [1:0]  Hresp_m;
  logic [31:0] Hrdata_m;

  ahb_apb_arbiter dut (
    .Hclk(Hclk), .Hrst(Hrst), .Hbusreq(Hbusreq),
    .Haddr_m0(Haddr_m0), .Haddr_m1(Haddr_m1),
    .Htrans_m0(Htrans_m0), .Htrans_m1(Htrans_m1),
    .Hwrite_m0(Hwrite_m0), .Hwrite_m1(Hwrite_m1),
    .Hwdata_m0(Hwdata_m0), .Hwdata_m1(Hwdata_m1),
    .Hready_out(Hready_out), .Hresp(Hresp), .Hrdata(Hrdata),
    .Hgrant(Hgrant), .Hmaster(Hmaster), .Hmaster_d(Hmaster_d),
    .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hwdata(Hwdata),
    .Hsel_APB(Hsel_APB), .Hready_m(Hready_m), .Hresp_m(Hresp_m), .Hrdata_m(Hrdata_m)
  );

  always #5 Hclk = ~Hclk;

  localparam int S_GRANT = 0, S_MASTER = 1, S_MASTER_D = 2, S_HADDR = 3, S_HSEL = 4,
                 S_HWDATA = 5, S_HRDATA = 6, S_HTRANS = 7, S_HREADY = 8, S_HRESP = 9;

  int cyc = 0;
  always @(posedge Hclk) cyc <= cyc + 1;

  // Scoreboard: expected (cycle, signal, value, name) entries
  int          exp_cyc[$];
  int          exp_sel[$];
  logic [31:0] exp_val[$];
  string       exp_name[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] dut_value(input int sel);
    case (sel)
      S_GRANT:    return {30'd0, Hgrant};
      S_MASTER:   return {31'd0, Hmaster};
      S_MASTER_D: return {31'd0, Hmaster_d};
      S_HADDR:    return Haddr;
      S_HSEL:     return {31'd0, Hsel_APB};
      S_HWDATA:   return Hwdata;
      S_HRDATA:   return Hrdata_m;
      S_HTRANS:   return {30'd0, Htrans};
      S_HREADY:   return {31'd0, Hready_m};
      S_HRESP:    return {30'd0, Hresp_m};
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle, sampling mid-cycle.
  always @(negedge Hclk) begin
    logic [31:0] act;
    while (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
      act = dut_value(exp_sel[0]);
      n_tests++;
      if (act !== exp_val[0]) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", exp_name[0], cyc, act, exp_val[0]);
      end
      void'(exp_cyc.pop_front());
      void'(exp_sel.pop_front());
      void'(exp_val.pop_front());
      void'(exp_name.pop_front());
    end
  end

  task automatic expect_sig(input int sel, input logic [31:0] val, input string name);
    exp_cyc.push_back(cyc);
    exp_sel.push_back(sel);
    exp_val.push_back(val);
    exp_name.push_back(name);
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic own(input logic [1:0] g, input string name);
    expect_sig(S_GRANT, {30'd0, g}, {name, "_grant"});
    expect_sig(S_MASTER, {31'd0, g[1]}, {name, "_master"});
  endtask

  initial begin
    Hrst = 1'b1; Hbusreq = 2'b00;
    Haddr_m0 = '0; Haddr_m1 = '0; Htrans_m0 = 2'b00; Htrans_m1 = 2'b00;
    Hwrite_m0 = 1'b0; Hwrite_m1 = 1'b0; Hwdata_m0 = '0; Hwdata_m1 = '0;
    Hready_out = 1'b1; Hresp = 2'b00; Hrdata = '0;

    // Reset
    step(); step();
    Hrst = 1'b0;
    own(2'b01, "reset");
    expect_sig(S_MASTER_D, 32'd0, "reset_master_d");
    expect_sig(S_HSEL, 32'd0, "reset_hsel");
    expect_sig(S_HTRANS, 32'd0, "reset_htrans");

    // Single read by master 1
    Hbusreq = 2'b10;
    step();
    own(2'b10, "m1_req");
    Htrans_m1 = 2'b10; Haddr_m1 = 32'h20;
    expect_sig(S_HADDR, 32'h20, "m1_haddr");
    expect_sig(S_HSEL, 32'd1, "m1_hsel");
    expect_sig(S_HTRANS, 32'd2, "m1_htrans");
    step();
    Htrans_m1 = 2'b00; Hbusreq = 2'b00; Hrdata = 32'd16;
    expect_sig(S_HRDATA, 32'd16, "m1_rdata");
    expect_sig(S_MASTER_D, 32'd1, "m1_master_d");
    expect_sig(S_GRANT, 32'h2, "m1_data_grant");
    step();
    Hrdata = '0;
    own(2'b01, "m1_park");
    expect_sig(S_MASTER_D, 32'd1, "m1_park_master_d");

    // Burst protection: master 1 requests throughout
    Hbusreq = 2'b11; Htrans_m0 = 2'b10; Haddr_m0 = 32'h0;
    expect_sig(S_GRANT, 32'h1, "burst_nonseq_grant");
    expect_sig(S_HSEL, 32'd1, "burst_hsel");
    step();
    Htrans_m0 = 2'b11; Haddr_m0 = 32'h100;
    expect_sig(S_GRANT, 32'h1, "burst_seq1_grant");
    expect_sig(S_HADDR, 32'h100, "burst_seq1_haddr");
    step();
    Haddr_m0 = 32'h1000;
    expect_sig(S_GRANT, 32'h1, "burst_seq2_grant");
    step();
    Haddr_m0 = 32'h1100;
    expect_sig(S_GRANT, 32'h1, "burst_seq3_grant");
    step();
    Htrans_m0 = 2'b00;
    expect_sig(S_GRANT, 32'h1, "burst_idle_grant");
    step();
    own(2'b10, "burst_handover");

    // Tie alternation: both request, one transfer each then IDLE
    for (int i = 0; i < 3; i++) begin
      if (Hmaster) begin Htrans_m1 = 2'b10; Haddr_m1 = 32'h40; end
      else begin Htrans_m0 = 2'b10; Haddr_m0 = 32'h4; end
      step();
      Htrans_m0 = 2'b00; Htrans_m1 = 2'b00;
      step();
      own((i % 2 == 0) ? 2'b01 : 2'b10, $sformatf("tie%0d", i));
    end

    // Write data lag: master 0 owns, writes 0xFF, then hands over
    Htrans_m0 = 2'b10; Haddr_m0 = 32'h0; Hwrite_m0 = 1'b1; Hwdata_m1 = 32'h0000_AAAA;
    step();
    Htrans_m0 = 2'b00; Hwrite_m0 = 1'b0; Hwdata_m0 = 32'h0000_00FF;
    expect_sig(S_HWDATA, 32'hFF, "wr_data_phase");
    step();
    own(2'b10, "wr_handover");
    expect_sig(S_HWDATA, 32'hFF, "wr_lag_hwdata");
    expect_sig(S_MASTER_D, 32'd0, "wr_lag_master_d");
    Htrans_m1 = 2'b10; Haddr_m1 = 32'h8;
    step();
    Htrans_m1 = 2'b00;
    expect_sig(S_MASTER_D, 32'd1, "wr_m1_master_d");
    expect_sig(S_HWDATA, 32'hAAAA, "wr_m1_hwdata");

    // Stall: owner master 0 idle, master 1 requesting, Hready_out low
    Hbusreq = 2'b01;
    step();
    own(2'b01, "stall_m0_own");
    Hbusreq = 2'b10; Hready_out = 1'b0; Hresp = 2'b01;
    expect_sig(S_HREADY, 32'd0, "stall_hready_m");
    expect_sig(S_HRESP, 32'd1, "stall_hresp_m");
    for (int i = 0; i < 3; i++) begin
      step();
      own(2'b01, $sformatf("stall%0d", i));
    end
    Hready_out = 1'b1; Hresp = 2'b00;
    step();
    own(2'b10, "stall_release");
    Htrans_m1 = 2'b10; Haddr_m1 = 32'h0002_0000;
    expect_sig(S_HADDR, 32'h0002_0000, "oow_haddr");
    expect_sig(S_HSEL, 32'd0, "oow_hsel");
    step();
    expect_sig(S_MASTER_D, 32'd1, "pre_reset_master_d");

    // Reset in the middle of a transfer
    Hrst = 1'b1;
    step();
    Hrst = 1'b0; Hbusreq = 2'b00; Htrans_m1 = 2'b00;
    own(2'b01, "midrst");
    expect_sig(S_MASTER_D, 32'd0, "midrst_master_d");
    expect_sig(S_HTRANS, 32'd0, "midrst_htrans");

    step(); step();
    if (exp_cyc.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_cyc.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
